// File: rtl/corr_pkg.sv
// Shared parameters, types and helpers for the correlation accumulator stage.
// PIXEL_SIZE and NUM_TEMPLATES live here so every correlation block sees the same values.
package corr_pkg;

  localparam int PIXEL_SIZE     = 8;
  localparam int NUM_TEMPLATES  = 2;
  localparam int DEFAULT_WINDOW = 16;
  localparam int ACC_W_DEFAULT  = 2*PIXEL_SIZE + $clog2(DEFAULT_WINDOW);

  typedef logic [ACC_W_DEFAULT-1:0] acc_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // Index width that never collapses to zero bits when there is a single template.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/correlation_accumulator_if.sv
// Sample-in / window-sums-out handshake bundle of the correlation accumulator.
// Optional argmax signals appear only when CORR_ACC_ARGMAX_EN is defined.
interface correlation_accumulator_if
  import corr_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = $clog2(DEFAULT_WINDOW)
);

  localparam int IDX_W = clog2_min1(NUM_TEMPLATES);

  logic                                       in_valid;
  logic                                       in_ready;
  logic [2*PIXEL_SIZE-1:0]                    I_in;
  logic [2*PIXEL_SIZE-1:0]                    I_square_in;
  logic [NUM_TEMPLATES-1:0][2*PIXEL_SIZE-1:0] T_x_I_in;
  logic                                       out_valid;
  logic                                       out_ready;
  logic [ACC_W-1:0]                           sum_I;
  logic [ACC_W-1:0]                           sum_I_sq;
  logic [NUM_TEMPLATES-1:0][ACC_W-1:0]        sum_T_x_I;
  logic [CNT_W-1:0]                           sample_cnt;
`ifdef CORR_ACC_ARGMAX_EN
  logic [IDX_W-1:0]                           best_idx;
  logic [ACC_W-1:0]                           best_sum;
`endif

  modport master (
    output in_valid, I_in, I_square_in, T_x_I_in, out_ready,
    input  in_ready, out_valid, sum_I, sum_I_sq, sum_T_x_I, sample_cnt
`ifdef CORR_ACC_ARGMAX_EN
    , input best_idx, best_sum
`endif
  );

  modport slave (
    input  in_valid, I_in, I_square_in, T_x_I_in, out_ready,
    output in_ready, out_valid, sum_I, sum_I_sq, sum_T_x_I, sample_cnt
`ifdef CORR_ACC_ARGMAX_EN
    , output best_idx, best_sum
`endif
  );

endinterface

// File: rtl/corr_argmax_tree.sv
// Compare-reduce over the per-template window sums; ties keep the lowest index.
module corr_argmax_tree
  import corr_pkg::*;
#(
  parameter int N = NUM_TEMPLATES,
  parameter int W = ACC_W_DEFAULT,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0][W-1:0] sums,
  output logic [IDX_W-1:0]    best_idx,
  output logic [W-1:0]        best_sum
);

  // Strict greater-than keeps the earlier index on equal sums.
  always_comb begin
    best_idx = '0;
    best_sum = sums[0];
    for (int k = 1; k < N; k++) begin
      if (sums[k] > best_sum) begin
        best_sum = sums[k];
        best_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/correlation_accumulator.sv
// Sums I, I^2 and T*I over WINDOW_SIZE accepted samples and hands the window sums on.
// Define CORR_ACC_ARGMAX_EN to add the registered best_idx/best_sum outputs.
module correlation_accumulator
  import corr_pkg::*;
#(
  parameter int WINDOW_SIZE = 16,
  parameter int ACC_W       = 2*PIXEL_SIZE + $clog2(WINDOW_SIZE)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      clear,
  correlation_accumulator_if.slave  bus
);

  localparam int              CNT_W     = $clog2(WINDOW_SIZE);
  localparam int              MIN_ACC_W = 2*PIXEL_SIZE + $clog2(WINDOW_SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_SIZE - 1);

  generate
    if (WINDOW_SIZE < 2) begin : g_bad_window
      $error("correlation_accumulator: WINDOW_SIZE must be at least 2");
    end
    if (ACC_W < MIN_ACC_W) begin : g_bad_acc_w
      $error("correlation_accumulator: ACC_W too narrow, window sums could wrap");
    end
  endgenerate

  acc_state_e                          state, state_next;
  logic [CNT_W-1:0]                    cnt;
  logic [ACC_W-1:0]                    acc_i, acc_sq;
  logic [NUM_TEMPLATES-1:0][ACC_W-1:0] acc_txi;
  logic [ACC_W-1:0]                    next_i, next_sq;
  logic [NUM_TEMPLATES-1:0][ACC_W-1:0] next_txi;
  logic                                is_last, accept, take_out, win_done;

  assign is_last        = (cnt == LAST_CNT);
  assign bus.in_ready   = !(bus.out_valid && !bus.out_ready && is_last);
  assign accept         = bus.in_valid && bus.in_ready;
  assign take_out       = bus.out_valid && bus.out_ready;
  assign win_done       = accept && is_last && !clear;
  assign bus.sample_cnt = cnt;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // A new window starts from the incoming sample alone, so IDLE ignores the accumulators.
  always_comb begin
    state_next = state;
    next_i     = ACC_W'(bus.I_in);
    next_sq    = ACC_W'(bus.I_square_in);
    for (int k = 0; k < NUM_TEMPLATES; k++) next_txi[k] = ACC_W'(bus.T_x_I_in[k]);
    if (state == ACCUM) begin
      next_i  = next_i + acc_i;
      next_sq = next_sq + acc_sq;
      for (int k = 0; k < NUM_TEMPLATES; k++) next_txi[k] = next_txi[k] + acc_txi[k];
    end
    if (clear)       state_next = IDLE;
    else if (accept) state_next = is_last ? IDLE : ACCUM;
  end

`ifdef CORR_ACC_ARGMAX_EN
  localparam int IDX_W = clog2_min1(NUM_TEMPLATES);
  logic [IDX_W-1:0] best_idx_next;
  logic [ACC_W-1:0] best_sum_next;

  corr_argmax_tree #(.N(NUM_TEMPLATES), .W(ACC_W), .IDX_W(IDX_W)) u_argmax (
    .sums     (next_txi),
    .best_idx (best_idx_next),
    .best_sum (best_sum_next)
  );
`endif

  // clear wins over a same-cycle sample; the output buffer only reacts to handshakes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt           <= '0;
      acc_i         <= '0;
      acc_sq        <= '0;
      acc_txi       <= '0;
      bus.out_valid <= 1'b0;
      bus.sum_I     <= '0;
      bus.sum_I_sq  <= '0;
      bus.sum_T_x_I <= '0;
`ifdef CORR_ACC_ARGMAX_EN
      bus.best_idx  <= '0;
      bus.best_sum  <= '0;
`endif
    end else begin
      if (clear) begin
        cnt     <= '0;
        acc_i   <= '0;
        acc_sq  <= '0;
        acc_txi <= '0;
      end else if (accept) begin
        if (is_last) begin
          cnt           <= '0;
          acc_i         <= '0;
          acc_sq        <= '0;
          acc_txi       <= '0;
          bus.sum_I     <= next_i;
          bus.sum_I_sq  <= next_sq;
          bus.sum_T_x_I <= next_txi;
`ifdef CORR_ACC_ARGMAX_EN
          bus.best_idx  <= best_idx_next;
          bus.best_sum  <= best_sum_next;
`endif
        end else begin
          cnt     <= cnt + CNT_W'(1);
          acc_i   <= next_i;
          acc_sq  <= next_sq;
          acc_txi <= next_txi;
        end
      end
      if (win_done)      bus.out_valid <= 1'b1;
      else if (take_out) bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_correlation_accumulator.sv
// Randomised and directed bench for correlation_accumulator against a window-level reference model.
// Argmax checks are compiled in when CORR_ACC_ARGMAX_EN is defined.
module tb_correlation_accumulator;
  import corr_pkg::*;

  localparam int W  = 4;
  localparam int AW = 2*PIXEL_SIZE + $clog2(W);
  localparam int CW = $clog2(W);

  typedef struct {
    int i;
    int t [NUM_TEMPLATES];
  } sample_t;

  logic CLK = 1'b0;
  logic RST;
  logic clear;

  always #5 CLK = ~CLK;

  correlation_accumulator_if #(.ACC_W(AW), .CNT_W(CW)) bus ();

  correlation_accumulator #(.WINDOW_SIZE(W), .ACC_W(AW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .clear (clear),
    .bus   (bus.slave)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: the samples of the open window and the single pending result.
  sample_t winQ[$];
  bit      pend;
  longint  expI, expSq;
  longint  expT [NUM_TEMPLATES];
  int      expBest;
  longint  expBestSum;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input longint expected);
    testsRun++;
    if (actual !== 64'(expected)) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic sample_t mk(input int i, input int t0, input int t1);
    sample_t s;
    s.i = i;
    for (int k = 0; k < NUM_TEMPLATES; k++) s.t[k] = (k == 0) ? t0 : t1;
    return s;
  endfunction

  function automatic sample_t rnd();
    sample_t s;
    s.i = int'($urandom_range(0, 255));
    for (int k = 0; k < NUM_TEMPLATES; k++) s.t[k] = int'($urandom_range(0, 255));
    return s;
  endfunction

  task automatic closeWindow();
    expI = 0;
    expSq = 0;
    for (int k = 0; k < NUM_TEMPLATES; k++) expT[k] = 0;
    foreach (winQ[n]) begin
      expI  += winQ[n].i;
      expSq += winQ[n].i * winQ[n].i;
      for (int k = 0; k < NUM_TEMPLATES; k++) expT[k] += longint'(winQ[n].t[k]) * winQ[n].i;
    end
    expBest = 0;
    for (int k = 1; k < NUM_TEMPLATES; k++) if (expT[k] > expT[expBest]) expBest = k;
    expBestSum = expT[expBest];
    winQ.delete();
  endtask

  // One clock of stimulus: drive, check before the edge, then advance the model.
  task automatic applyStimulus(input bit v, input bit clr, input bit ordy, input sample_t s);
    bit expReady;
    bit done;
    bus.in_valid    = v;
    bus.I_in        = 16'(s.i);
    bus.I_square_in = 16'(s.i * s.i);
    for (int k = 0; k < NUM_TEMPLATES; k++) bus.T_x_I_in[k] = 16'(s.t[k] * s.i);
    clear         = clr;
    bus.out_ready = ordy;
    @(negedge CLK);
    expReady = !(pend && !ordy && winQ.size() == W - 1);
    checkOutput("in_ready", bus.in_ready, expReady);
    checkOutput("out_valid", bus.out_valid, pend);
    checkOutput("sample_cnt", bus.sample_cnt, winQ.size());
    if (pend) begin
      checkOutput("sum_I", bus.sum_I, expI);
      checkOutput("sum_I_sq", bus.sum_I_sq, expSq);
      for (int k = 0; k < NUM_TEMPLATES; k++) checkOutput($sformatf("sum_T_x_I[%0d]", k), bus.sum_T_x_I[k], expT[k]);
`ifdef CORR_ACC_ARGMAX_EN
      checkOutput("best_idx", bus.best_idx, expBest);
      checkOutput("best_sum", bus.best_sum, expBestSum);
`endif
    end
    done = 1'b0;
    if (clr) winQ.delete();
    else if (v && expReady) begin
      winQ.push_back(s);
      if (winQ.size() == W) begin
        closeWindow();
        done = 1'b1;
      end
    end
    if (done) pend = 1'b1;
    else if (pend && ordy) pend = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic applyReset();
    RST = 1'b1;
    bus.in_valid = 1'b0;
    clear = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    winQ.delete();
    pend = 1'b0;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_sample_cnt", bus.sample_cnt, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_sum_I", bus.sum_I, 0);
    checkOutput("rst_sum_I_sq", bus.sum_I_sq, 0);
    for (int k = 0; k < NUM_TEMPLATES; k++) checkOutput("rst_sum_T_x_I", bus.sum_T_x_I[k], 0);
`ifdef CORR_ACC_ARGMAX_EN
    checkOutput("rst_best_idx", bus.best_idx, 0);
    checkOutput("rst_best_sum", bus.best_sum, 0);
`endif
  endtask

  initial begin
    RST = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.I_in = '0;
    bus.I_square_in = '0;
    bus.T_x_I_in = '0;
    pend = 1'b0;
    @(negedge CLK);
    applyReset();

    // Basic window 1..4 with T=2 and T=1.
    for (int n = 1; n <= 4; n++) applyStimulus(1, 0, 1, mk(n, 2, 1));
    checkOutput("basic_out_valid", bus.out_valid, 1);
    checkOutput("basic_sum_I", bus.sum_I, 10);
    checkOutput("basic_sum_I_sq", bus.sum_I_sq, 30);
    checkOutput("basic_sum_T0", bus.sum_T_x_I[0], 20);
    checkOutput("basic_sum_T1", bus.sum_T_x_I[1], 10);
`ifdef CORR_ACC_ARGMAX_EN
    checkOutput("basic_best_idx", bus.best_idx, 0);
    checkOutput("basic_best_sum", bus.best_sum, 20);
`endif

    // Back-pressure: consumer stalls while a second window fills.
    for (int n = 5; n <= 7; n++) applyStimulus(1, 0, 0, mk(n, 1, 3));
    applyStimulus(1, 0, 0, mk(8, 1, 3));
    applyStimulus(1, 0, 0, mk(8, 1, 3));
    checkOutput("bp_hold_sum_I", bus.sum_I, 10);
    applyStimulus(1, 0, 1, mk(8, 1, 3));
    checkOutput("bp_win2_sum_I", bus.sum_I, 26);
    applyStimulus(0, 0, 0, mk(0, 0, 0));
    applyStimulus(0, 0, 1, mk(0, 0, 0));

    // Maximum values: no wrap at the minimum accumulator width.
    for (int n = 0; n < 4; n++) applyStimulus(1, 0, 1, mk(255, 255, 255));
    checkOutput("max_sum_I", bus.sum_I, 1020);
    checkOutput("max_sum_I_sq", bus.sum_I_sq, 260100);
    checkOutput("max_sum_T0", bus.sum_T_x_I[0], 260100);

    // clear with a simultaneous sample, then a fresh window of fives.
    applyStimulus(1, 0, 1, mk(1, 1, 1));
    applyStimulus(1, 0, 1, mk(2, 1, 1));
    applyStimulus(1, 1, 1, mk(9, 1, 1));
    for (int n = 0; n < 4; n++) applyStimulus(1, 0, 1, mk(5, 1, 2));
    checkOutput("clr_sum_I", bus.sum_I, 20);
    checkOutput("clr_sum_I_sq", bus.sum_I_sq, 100);

    // Reset with sample_cnt=3 and a result still pending.
    for (int n = 0; n < 3; n++) applyStimulus(1, 0, 0, mk(7, 3, 4));
    checkOutput("pre_rst_cnt", bus.sample_cnt, 3);
    applyReset();
    for (int n = 0; n < 4; n++) applyStimulus(1, 0, 1, mk(1, 1, 1));
    checkOutput("post_rst_sum_I", bus.sum_I, 4);

`ifdef CORR_ACC_ARGMAX_EN
    // Equal template products must resolve to the lowest index.
    for (int n = 0; n < 4; n++) applyStimulus(1, 0, 1, mk(3, 2, 2));
    checkOutput("tie_best_idx", bus.best_idx, 0);
    checkOutput("tie_best_sum", bus.best_sum, 24);
`endif

    // Randomised traffic with sporadic clear, stalls and resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) applyReset();
      else applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                         $urandom_range(0, 9) < 6, rnd());
    end
    applyStimulus(0, 0, 1, mk(0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
